// File: rtl/subtrator_serial_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | subtrator_defs : shared state encodings and default width          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package subtrator_defs;

  localparam int N_PADRAO = 8;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/subtrator_serial_completo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | subtrator_completo : combinational one-bit full subtractor         |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module subtrator_completo (
  input  logic A,
  input  logic B,
  input  logic B_in,
  output logic D,
  output logic B_out
);

  always_comb begin
    D     = A ^ B ^ B_in;
    B_out = (~A & B) | (~(A ^ B) & B_in);
  end

endmodule
`default_nettype wire

// File: rtl/subtrator_serial.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | subtrator_serial : bit-serial N-bit subtractor, D = A - B - B_in   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module subtrator_serial
  import subtrator_defs::*;
#(
  parameter int N = N_PADRAO
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         B_in,
  output logic [N-1:0] D,
  output logic         B_out,
  output logic         V,
  output logic         ocupado,
  output logic         pronto
);

  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  estado_t       state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bw_q, bw_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic          bout_q, bout_d, v_q, v_d, ocupado_q, ocupado_d, pronto_q, pronto_d;
  logic          fs_d, fs_bout;

  subtrator_completo u_fs (
    .A     (a_q[0]),
    .B     (b_q[0]),
    .B_in  (bw_q),
    .D     (fs_d),
    .B_out (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bout_d  = bout_q;
    v_d     = v_q;
    case (state_q)
      OCIOSO: begin
        if (inicio) begin
          a_d     = A;
          b_d     = B;
          bw_d    = B_in;
          a_msb_d = A[N-1];
          b_msb_d = B[N-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = CALCULA;
        end
      end
      CALCULA: begin
        // Operands shift right so bit i always sits at position 0; result fills from the MSB.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bw_d  = fs_bout;
        res_d = {fs_d, res_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          dout_d  = res_d;
          bout_d  = fs_bout;
          v_d     = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
          state_d = FIM;
        end
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
    ocupado_d = (state_d == CALCULA);
    pronto_d  = (state_d == FIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OCIOSO;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
      bw_q      <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      bout_q    <= 1'b0;
      v_q       <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
      bw_q      <= bw_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      bout_q    <= bout_d;
      v_q       <= v_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign D       = dout_q;
  assign B_out   = bout_q;
  assign V       = v_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;

endmodule
`default_nettype wire

// File: tb/tb_subtrator_serial.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_subtrator_serial : randomized bench with arithmetic reference   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_subtrator_serial;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inicio = 1'b0;
  logic [N-1:0] A = '0, B = '0;
  logic         B_in = 1'b0;
  logic [N-1:0] D;
  logic         B_out, V, ocupado, pronto;

  logic fa, fb, fbin, fd, fbout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] exp_d    = '0;
  logic         exp_bout = 1'b0;
  logic         exp_v    = 1'b0;

  always #5 clk = ~clk;

  subtrator_serial #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
    .B_in    (B_in),
    .D       (D),
    .B_out   (B_out),
    .V       (V),
    .ocupado (ocupado),
    .pronto  (pronto)
  );

  subtrator_completo u_cell (
    .A     (fa),
    .B     (fb),
    .B_in  (fbin),
    .D     (fd),
    .B_out (fbout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (N+1)-bit arithmetic; V from the latched sign bits and the result sign.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    logic [N:0] diff;
    diff     = {1'b0, a} - {1'b0, b} - (N + 1)'(bin);
    exp_d    = diff[N-1:0];
    exp_bout = diff[N];
    exp_v    = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
  endtask

  // Starts one operation from OCIOSO and follows it through CALCULA and FIM.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input logic hold, input logic [N-1:0] a_after);
    logic [N-1:0] prev_d;
    logic         prev_bout, prev_v;
    prev_d    = exp_d;
    prev_bout = exp_bout;
    prev_v    = exp_v;
    inicio = 1'b1; A = a; B = b; B_in = bin;
    @(posedge clk); #1;
    inicio = hold;
    A      = a_after;
    B      = N'($urandom);
    B_in   = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      check("ocupado_calc", 32'(ocupado), 32'd1);
      check("pronto_calc", 32'(pronto), 32'd0);
      check("d_stable", 32'(D), 32'(prev_d));
      check("bout_stable", 32'(B_out), 32'(prev_bout));
      check("v_stable", 32'(V), 32'(prev_v));
      @(posedge clk); #1;
    end
    model(a, b, bin);
    check("pronto_fim", 32'(pronto), 32'd1);
    check("ocupado_fim", 32'(ocupado), 32'd0);
    check("d_result", 32'(D), 32'(exp_d));
    check("bout_result", 32'(B_out), 32'(exp_bout));
    check("v_result", 32'(V), 32'(exp_v));
    @(posedge clk); #1;
    inicio = 1'b0;
    check("pronto_low", 32'(pronto), 32'd0);
    check("ocupado_idle", 32'(ocupado), 32'd0);
    check("d_hold", 32'(D), 32'(exp_d));
  endtask

  initial begin
    // Full-subtractor cell, all 8 combinations.
    for (int i = 0; i < 8; i++) begin
      logic [1:0] r;
      {fa, fb, fbin} = 3'(i);
      #1;
      r = {1'b0, fa} - {1'b0, fb} - {1'b0, fbin};
      check("cell_d", 32'(fd), 32'(r[0]));
      check("cell_bout", 32'(fbout), 32'(r[1]));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_d", 32'(D), 32'd0);
    check("rst_bout", 32'(B_out), 32'd0);
    check("rst_v", 32'(V), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h00);
    do_op(8'h00, 8'h01, 1'b0, 1'b0, 8'h33);
    do_op(8'h80, 8'h01, 1'b0, 1'b0, 8'h00);
    do_op(8'h7F, 8'hFF, 1'b0, 1'b0, 8'h00);
    do_op(8'h10, 8'h0F, 1'b1, 1'b0, 8'h00);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    do_op(8'h09, 8'h04, 1'b0, 1'b1, 8'hAA);

    // Abort mid-operation: rst seen at the edge ending the 4th CALCULA cycle.
    inicio = 1'b1; A = 8'hC3; B = 8'h15; B_in = 1'b0;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_ocupado", 32'(ocupado), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_d = '0; exp_bout = 1'b0; exp_v = 1'b0;
    check("abort_d", 32'(D), 32'd0);
    check("abort_bout", 32'(B_out), 32'd0);
    check("abort_v", 32'(V), 32'd0);
    check("abort_ocupado", 32'(ocupado), 32'd0);
    for (int i = 0; i < N + 3; i++) begin
      check("abort_no_pronto", 32'(pronto), 32'd0);
      @(posedge clk); #1;
    end

    do_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h00);

    for (int t = 0; t < 24; t++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), N'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
